aes_decrypt_core: RTL

Iterative AES-128 decryption core; the inverse counterpart of the existing encryption datapath.
- Owns its own controller FSM and handshake.
- Expands the cipher key forward to the last round key, then runs 10 inverse rounds, one per cycle, regenerating round keys backwards on the fly.
- Sits beside the encryption core behind the same testbench/host interface style.

---
 rtl/aes_decrypt_core_pkg.sv | 84 ++++++++
 rtl/aes_decrypt_core_key_step.sv | 32 +++
 rtl/aes_decrypt_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aes_decrypt_core_pkg.sv
// rtl/aes_decrypt_core_pkg.sv - shared AES constants, GF(2^8) helpers, S-boxes and FSM states
package aes_decrypt_core_pkg;
   localparam int AES_BLK = 128;
   localparam int NR      = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      DEC    = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   // General multiply, only used to build the field inverse.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      logic [7:0] bb;
      acc = 8'h00;
      x   = a;
      bb  = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) acc = acc ^ x;
         x  = xtime(x);
         bb = bb >> 1;
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) begin
         r = gmul(gmul(r, r), a);
      end
      return gmul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = ginv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction
endpackage

// File: rtl/aes_decrypt_core_key_step.sv
// rtl/aes_decrypt_core_key_step.sv - one AES-128 key schedule step, forward or reverse
module aes_key_step (
   input  logic         dir,
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon_in,
   output logic [127:0] key_out
);
   import aes_decrypt_core_pkg::*;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p1, p2, p3;
   logic [31:0] sw_in, sw;

   // Both directions share one SubWord(RotWord()) unit; reverse feeds it w3^w2 (the old w3).
   always_comb begin
      w0 = key_in[127:96];
      w1 = key_in[95:64];
      w2 = key_in[63:32];
      w3 = key_in[31:0];
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      sw_in = dir ? p3 : w3;
      sw = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])}
           ^ {rcon_in, 24'h000000};
      if (dir) begin
         key_out = {w0 ^ sw, p1, p2, p3};
      end else begin
         key_out = {w0 ^ sw, w0 ^ sw ^ w1, w0 ^ sw ^ w1 ^ w2, w0 ^ sw ^ w1 ^ w2 ^ w3};
      end
   end
endmodule

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES-128 decryption core with last-round-key cache
module aes_decrypt_core #(
   parameter int NR        = 10,
   parameter int KEY_CACHE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         reuse_key,
   input  logic [127:0] cipher_key,
   input  logic [127:0] cipher_text,
   output logic         busy,
   output logic         done,
   output logic [127:0] plain_text
);
   import aes_decrypt_core_pkg::*;

   localparam logic [3:0] LAST_KEY = 4'(NR);
   localparam logic [3:0] LAST_DEC = 4'(NR - 1);

   state_e       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] cache_q, cache_d;
   logic [127:0] pt_q, pt_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         key_valid_q, key_valid_d;

   logic         step_dir;
   logic [7:0]   step_rcon;
   logic [127:0] next_rk;
   logic [7:0]   ark [16];
   logic [127:0] mixed;
   logic [127:0] flat;
   logic [127:0] round_out;

   // In DEC the counter holds r, and stepping back from k_(r+1) needs rcon[r+1].
   assign step_dir  = (state_q == DEC);
   assign step_rcon = rcon(step_dir ? cnt_q + 4'd1 : cnt_q);

   aes_key_step u_key_step (
      .dir     (step_dir),
      .key_in  (rk_q),
      .rcon_in (step_rcon),
      .key_out (next_rk)
   );

   // InvShiftRows + InvSubBytes + AddRoundKey with the freshly regenerated round key.
   for (genvar i = 0; i < 16; i++) begin : g_isb
      localparam int C   = i / 4;
      localparam int R   = i % 4;
      localparam int SRC = 4 * ((C - R + 4) % 4) + R;
      assign ark[i] = inv_sbox(st_q[127-8*SRC -: 8]) ^ next_rk[127-8*i -: 8];
   end

   // InvMixColumns per column; the final round (r=0) takes the unmixed bytes.
   for (genvar c = 0; c < 4; c++) begin : g_imc
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark[4*c];
      assign a1 = ark[4*c+1];
      assign a2 = ark[4*c+2];
      assign a3 = ark[4*c+3];
      assign mixed[127-32*c -: 32] = {
         gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
         gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
         gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
         gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
      assign flat[127-32*c -: 32] = {a0, a1, a2, a3};
   end

   assign round_out = (cnt_q == 4'd0) ? flat : mixed;

   // Controller next-state and datapath register updates.
   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      rk_d        = rk_q;
      cache_d     = cache_q;
      pt_d        = pt_q;
      cnt_d       = cnt_q;
      key_valid_d = key_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if ((KEY_CACHE != 0) && reuse_key && key_valid_q) begin
                  rk_d    = cache_q;
                  st_d    = cipher_text ^ cache_q;
                  cnt_d   = LAST_DEC;
                  state_d = DEC;
               end else begin
                  rk_d    = cipher_key;
                  st_d    = cipher_text;
                  cnt_d   = 4'd1;
                  state_d = KEYEXP;
               end
            end
         end
         KEYEXP: begin
            rk_d = next_rk;
            if (cnt_q == LAST_KEY) begin
               st_d        = st_q ^ next_rk;
               cache_d     = (KEY_CACHE != 0) ? next_rk : cache_q;
               key_valid_d = (KEY_CACHE != 0);
               cnt_d       = LAST_DEC;
               state_d     = DEC;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DEC: begin
            rk_d = next_rk;
            st_d = round_out;
            if (cnt_q == 4'd0) begin
               pt_d    = round_out;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset clears everything and drops any cached key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         st_q        <= '0;
         rk_q        <= '0;
         cache_q     <= '0;
         pt_q        <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         rk_q        <= rk_d;
         cache_q     <= cache_d;
         pt_q        <= pt_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign busy       = (state_q == KEYEXP) || (state_q == DEC);
   assign done       = (state_q == DONE);
   assign plain_text = pt_q;
endmodule
